// File: rtl/bit_serial_adder_pkg.sv
// rtl/bit_serial_adder_pkg.sv - shared state encoding and counter sizing for bit_serial_adder
package bit_serial_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    // Bit counter must index 0..width-1; never narrower than one bit.
    function automatic int cnt_width(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/bit_serial_adder_full_adder.sv
// rtl/bit_serial_adder_full_adder.sv - single-bit full adder cell
module bit_serial_adder_full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/bit_serial_adder.sv
// rtl/bit_serial_adder.sv - LSB-first bit-serial adder sequencing one full adder cell
module bit_serial_adder
    import bit_serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = cnt_width(WIDTH);

    state_t             state_q;
    state_t             state_d;
    logic [WIDTH-1:0]   a_sh;
    logic [WIDTH-1:0]   b_sh;
    logic [WIDTH-2:0]   s_sh;
    logic               carry_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   sum_q;
    logic               cout_q;
    logic               accept;
    logic               last_bit;
    logic               fa_s;
    logic               fa_co;
    logic [WIDTH-1:0]   s_next;

    bit_serial_adder_full_adder u_fa (
        .a  (a_sh[0]),
        .b  (b_sh[0]),
        .ci (carry_q),
        .s  (fa_s),
        .co (fa_co)
    );

    // s_sh holds the bits already produced; the current bit lands on top.
    assign s_next = {fa_s, s_sh};

    always_comb begin
        state_d  = ST_IDLE;
        busy     = 1'b0;
        done     = 1'b0;
        accept   = 1'b0;
        last_bit = 1'b0;
        case (state_q)
            ST_IDLE: begin
                accept  = start;
                state_d = start ? ST_RUN : ST_IDLE;
            end
            ST_RUN: begin
                busy     = 1'b1;
                last_bit = (cnt_q == CNT_W'(WIDTH - 1));
                state_d  = last_bit ? ST_FIN : ST_RUN;
            end
            ST_FIN: begin
                done    = 1'b1;
                accept  = start;
                state_d = start ? ST_RUN : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh    <= '0;
            b_sh    <= '0;
            s_sh    <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else if (accept) begin
            a_sh    <= a;
            b_sh    <= b;
            s_sh    <= '0;
            carry_q <= cin;
            cnt_q   <= '0;
        end else if (state_q == ST_RUN) begin
            a_sh    <= a_sh >> 1;
            b_sh    <= b_sh >> 1;
            s_sh    <= s_next[WIDTH-1:1];
            carry_q <= fa_co;
            cnt_q   <= cnt_q + CNT_W'(1);
            if (last_bit) begin
                sum_q  <= s_next;
                cout_q <= fa_co;
            end
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_bit_serial_adder.sv
// tb/tb_bit_serial_adder.sv - directed self-checking bench for bit_serial_adder (WIDTH=8 and WIDTH=4)
module tb_bit_serial_adder;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;

    logic       start4;
    logic [3:0] a4;
    logic [3:0] b4;
    logic       cin4;
    logic       busy4;
    logic       done4;
    logic [3:0] sum4;
    logic       cout4;

    int n_cmp;
    int n_err;
    int lat;
    int busy_cnt;
    int first_done;
    int n_done;

    bit_serial_adder #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    bit_serial_adder #(.WIDTH(4)) dut4 (
        .clk   (clk),
        .rst   (rst),
        .start (start4),
        .a     (a4),
        .b     (b4),
        .cin   (cin4),
        .busy  (busy4),
        .done  (done4),
        .sum   (sum4),
        .cout  (cout4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pulse start for one edge, then count samples until done (bounded).
    task automatic issue(input logic [7:0] av, input logic [7:0] bv, input logic cv);
        a     = av;
        b     = bv;
        cin   = cv;
        start = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        a        = 8'h00;
        b        = 8'h00;
        cin      = 1'b0;
        lat      = 1;
        busy_cnt = 0;
        while (!done && lat < 40) begin
            if (busy) busy_cnt++;
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_err  = 0;
        rst    = 1'b1;
        start  = 1'b0;
        a      = '0;
        b      = '0;
        cin    = 1'b0;
        start4 = 1'b0;
        a4     = '0;
        b4     = '0;
        cin4   = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_done", 32'(done), 32'h0);
        check("reset_sum",  32'(sum),  32'h0);
        check("reset_cout", 32'(cout), 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // 0x35 + 0x1C = 0x51
        issue(8'h35, 8'h1C, 1'b0);
        check("t1_latency", 32'(lat), 32'd9);
        check("t1_busy_cycles", 32'(busy_cnt), 32'd8);
        check("t1_sum",  32'(sum),  32'h51);
        check("t1_cout", 32'(cout), 32'h0);
        @(negedge clk);
        check("t1_done_pulse", 32'(done), 32'h0);
        check("t1_idle_busy",  32'(busy), 32'h0);
        check("t1_sum_hold",   32'(sum),  32'h51);

        // full carry ripple: 0xFF + 0x01 + 1 = 0x101
        issue(8'hFF, 8'h01, 1'b1);
        check("t2_latency", 32'(lat), 32'd9);
        check("t2_sum",  32'(sum),  32'h01);
        check("t2_cout", 32'(cout), 32'h1);
        @(negedge clk);

        // back-to-back: second start during the FIN cycle
        issue(8'h12, 8'h34, 1'b0);
        check("t3a_sum",  32'(sum),  32'h46);
        check("t3a_cout", 32'(cout), 32'h0);
        issue(8'h80, 8'h80, 1'b0);
        check("t3b_gap",  32'(lat),  32'd9);
        check("t3b_sum",  32'(sum),  32'h00);
        check("t3b_cout", 32'(cout), 32'h1);
        @(negedge clk);

        // start pulses and operand changes during RUN are ignored
        a     = 8'h3C;
        b     = 8'h0F;
        cin   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        first_done = 0;
        n_done     = 0;
        for (int i = 1; i <= 20; i++) begin
            if (i == 3 || i == 5) begin
                start = 1'b1;
                a     = 8'hFF;
                b     = 8'hFF;
                cin   = 1'b0;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                n_done++;
                if (first_done == 0) first_done = i;
            end
            if (i == 9) begin
                check("t4_sum",  32'(sum),  32'h4C);
                check("t4_cout", 32'(cout), 32'h0);
            end
            @(negedge clk);
        end
        check("t4_done_at", 32'(first_done), 32'd9);
        check("t4_done_count", 32'(n_done), 32'd1);
        check("t4_sum_hold", 32'(sum), 32'h4C);

        // reset during the fourth RUN cycle
        a     = 8'h77;
        b     = 8'h66;
        cin   = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("t5_busy_before_rst", 32'(busy), 32'h1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t5_busy", 32'(busy), 32'h0);
        check("t5_done", 32'(done), 32'h0);
        check("t5_sum",  32'(sum),  32'h0);
        check("t5_cout", 32'(cout), 32'h0);
        n_done = 0;
        for (int i = 0; i < 12; i++) begin
            if (done) n_done++;
            @(negedge clk);
        end
        check("t5_no_done", 32'(n_done), 32'd0);
        issue(8'h0A, 8'h05, 1'b0);
        check("t5_after_sum",  32'(sum),  32'h0F);
        check("t5_after_cout", 32'(cout), 32'h0);
        @(negedge clk);

        // exhaustive WIDTH=4 sweep, issued back-to-back
        for (int v = 0; v < 512; v++) begin
            a4     = v[3:0];
            b4     = v[7:4];
            cin4   = v[8];
            start4 = 1'b1;
            @(negedge clk);
            start4 = 1'b0;
            lat    = 1;
            while (!done4 && lat < 20) begin
                @(negedge clk);
                lat++;
            end
            check($sformatf("w4_done_%0d", v), 32'(done4), 32'h1);
            check($sformatf("w4_result_%0d", v), 32'({cout4, sum4}),
                  32'(v[3:0]) + 32'(v[7:4]) + 32'(v[8]));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/bit_serial_adder.md
Name: bit_serial_adder

Overview:
- Sequences a single FULL_ADDER cell over WIDTH clock cycles to add two WIDTH-bit operands bit-serially, LSB first.
- Keeps the carry in a flip-flop between bits.
- Trades WIDTH cycles of latency for one adder cell.
- Sits between a requester using a START/DONE handshake and any consumer of SUM/COUT.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
- CLK  input  1  clock, all state on rising edge
- RST  input  1  synchronous reset, active-high
- START  input  1  request; sampled only when block can accept
- A  input  WIDTH  operand A; captured on accepted START
- B  input  WIDTH  operand B; captured on accepted START
- CIN  input  1  carry-in; captured on accepted START
- BUSY  output  1  high while an addition is in progress
- DONE  output  1  one-cycle pulse; SUM/COUT valid from this cycle
- SUM  output  WIDTH  result register
- COUT  output  1  final carry-out

Behaviour:
- Clock and reset: one clock, CLK. Reset RST is synchronous and active-high.
- Reset state: all registers cleared; state=IDLE; BUSY=0, DONE=0, SUM=0, COUT=0. RST wins over every other input in the same cycle.
- States: IDLE, RUN, FIN.
- IDLE:
  - START=1 -> capture A, B into shift registers; carry_q<=CIN; cnt<=0; go RUN.
  - START=0 -> stay.
- RUN:
  - Each cycle, FULL_ADDER inputs are a_sh[0], b_sh[0], carry_q.
  - a_sh and b_sh shift right by 1.
  - S is shifted into s_sh at the MSB end (s_sh shifts right).
  - carry_q<=Co; cnt<=cnt+1.
  - When cnt==WIDTH-1 (last bit): load SUM with the final s_sh value (including this bit), COUT<=Co, go FIN.
- FIN:
  - DONE=1 for exactly this cycle.
  - START=1 -> accept a new operation exactly as in IDLE and go RUN (back-to-back allowed).
  - Otherwise go IDLE.
- BUSY=1 in RUN only.
- START while in RUN is ignored. It is not queued.
- Latency: accepted START at edge k -> DONE high during the cycle after edge k+WIDTH. Throughput is one add per WIDTH+1 cycles.
- SUM/COUT change only at the transition into FIN, and hold until the next completion or reset. No intermediate bits are visible on SUM.
- A/B/CIN may change freely after the accepting edge.
- Arithmetic: {COUT,SUM} = A + B + CIN, modulo 2^(WIDTH+1); no truncation.
- cnt width: $clog2(WIDTH). Counter never wraps in normal operation. Any unreachable state encoding returns to IDLE.
- Reset mid-RUN: operation is abandoned. SUM/COUT are cleared, and no DONE pulse is generated.

Decomposition:
- Shared package holds:
  - state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_FIN=2'd2;
  - a counter-width helper function.
- One sub-module: the existing FULL_ADDER cell, instantiated once. All sequencing (FSM, counter, shift registers, carry flop) lives in bit_serial_adder itself.

Test Plan:
- WIDTH=8: A=8'h35, B=8'h1C, CIN=0, one-cycle START -> BUSY high 8 cycles; DONE one cycle 9 cycles after START edge; SUM=8'h51, COUT=0.
- WIDTH=8: A=8'hFF, B=8'h01, CIN=1 -> SUM=8'h01, COUT=1. Carry ripples through all bits.
- Back-to-back: second START (A=8'h80, B=8'h80, CIN=0) asserted in the FIN cycle -> accepted with no IDLE gap; SUM=8'h00, COUT=1; second DONE arrives 9 cycles after first DONE.
- START pulses and changes to A/B during RUN -> ignored. Result equals the originally captured operands; exactly one DONE.
- RST asserted at cycle 4 of RUN -> next cycle state=IDLE, BUSY=0, SUM=0, COUT=0; no DONE. A subsequent START with A=8'h0A, B=8'h05 yields SUM=8'h0F.
- Randomised-with-scoreboard sweep, WIDTH=4 exhaustive (512 cases including CIN) -> {COUT,SUM} always equals A+B+CIN.
